// File: rtl/memory_access_unit.sv
// ---------------------------------------------------------------------------
// memory_access_unit
//
// Consumer end of the EX->MEMPREP pipeline register. Turns the MEMPREP-stage
// memory operation into a single-beat load or store on a req/ready data-memory
// port. While an access is outstanding, it freezes the pipeline through
// `stall`. Load data is aligned and sign- or zero-extended before it is
// returned.
//
// Ports
//   clk, rst             : clock and synchronous active-high reset
//   invalid_MEMPREP      : stage holds a bubble; other stage inputs are ignored
//   mem_read_MEMPREP     : load request
//   mem_write_MEMPREP    : store request
//   funct3_MEMPREP       : RISC-V width/sign code
//   alu_result_MEMPREP   : effective byte address
//   store_data_MEMPREP   : rs2 value for stores
//   stall                : freeze request to all pipeline registers
//   dmem_req/we/addr/wdata/wstrb : registered memory request, held until ready
//   dmem_ready, dmem_rdata : memory handshake / load word
//   load_result, load_valid : extended load value and its one-cycle strobe
//   misaligned_fault     : one-cycle pulse when an illegal access is dropped
// ---------------------------------------------------------------------------
module memory_access_unit #(
  parameter int ADDR_W = 32  // must not exceed 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              invalid_MEMPREP,
  input  logic              mem_read_MEMPREP,
  input  logic              mem_write_MEMPREP,
  input  logic [2:0]        funct3_MEMPREP,
  input  logic [31:0]       alu_result_MEMPREP,
  input  logic [31:0]       store_data_MEMPREP,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_wstrb,
  input  logic              dmem_ready,
  input  logic [31:0]       dmem_rdata,
  output logic [31:0]       load_result,
  output logic              load_valid,
  output logic              misaligned_fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic              dmem_req_q;
  logic              dmem_we_q;
  logic [ADDR_W-1:0] dmem_addr_q;
  logic [31:0]       dmem_wdata_q;
  logic [3:0]        dmem_wstrb_q;
  logic [31:0]       load_result_q;
  logic              load_valid_q;
  logic              fault_q;
  logic              fault_d;

  // Attributes of the op in flight, needed to extract load data on completion.
  logic              op_load_q;
  logic [2:0]        op_funct3_q;
  logic [1:0]        op_off_q;

  // -------------------------------------------------------------------------
  // Decode of the MEMPREP operation
  // -------------------------------------------------------------------------
  logic        active;
  logic        both_set;
  logic        funct3_legal;
  logic        aligned;
  logic        legal_access;
  logic        fault_now;
  logic [1:0]  off;
  logic [31:0] addr_word;
  logic [3:0]  lane_wstrb;
  logic [31:0] lane_wdata;

  assign off       = alu_result_MEMPREP[1:0];
  assign addr_word = {alu_result_MEMPREP[31:2], 2'b00};

  always_comb begin
    active   = !invalid_MEMPREP && (mem_read_MEMPREP ^ mem_write_MEMPREP);
    both_set = !invalid_MEMPREP && mem_read_MEMPREP && mem_write_MEMPREP;

    funct3_legal = 1'b0;
    if (mem_read_MEMPREP) begin
      case (funct3_MEMPREP)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: funct3_legal = 1'b1;
        default:                                funct3_legal = 1'b0;
      endcase
    end else begin
      case (funct3_MEMPREP)
        3'b000, 3'b001, 3'b010: funct3_legal = 1'b1;
        default:                funct3_legal = 1'b0;
      endcase
    end

    // funct3[1:0] encodes the access size for every legal code.
    case (funct3_MEMPREP[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = !off[0];
      2'b10:   aligned = (off == 2'b00);
      default: aligned = 1'b0;
    endcase

    legal_access = active && funct3_legal && aligned;
    fault_now    = both_set || (active && !legal_access);
  end

  // Store lane placement: data is replicated across lanes so the memory only
  // needs the strobes to pick the right bytes.
  always_comb begin
    case (funct3_MEMPREP[1:0])
      2'b00: begin
        lane_wstrb = 4'b0001 << off;
        lane_wdata = {4{store_data_MEMPREP[7:0]}};
      end
      2'b01: begin
        lane_wstrb = off[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{store_data_MEMPREP[15:0]}};
      end
      default: begin
        lane_wstrb = 4'b1111;
        lane_wdata = store_data_MEMPREP;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Load extraction
  // -------------------------------------------------------------------------
  function automatic logic [31:0] extend_load(input logic [2:0]  f3,
                                              input logic [1:0]  lane,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  logic issue;
  logic complete;

  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    issue    = 1'b0;
    complete = 1'b0;
    fault_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (legal_access) begin
          stall   = 1'b1;
          issue   = 1'b1;
          state_d = BUSY;
        end
        fault_d = fault_now;
      end
      BUSY: begin
        stall = 1'b1;
        if (dmem_ready) begin
          complete = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        // The completed op is still sitting in MEMPREP this cycle; releasing
        // stall lets it leave, and going straight to IDLE avoids re-issuing it.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      dmem_addr_q   <= '0;
      dmem_wdata_q  <= '0;
      dmem_wstrb_q  <= '0;
      load_result_q <= '0;
      load_valid_q  <= 1'b0;
      fault_q       <= 1'b0;
      op_load_q     <= 1'b0;
      op_funct3_q   <= '0;
      op_off_q      <= '0;
    end else begin
      state_q      <= state_d;
      fault_q      <= fault_d;
      load_valid_q <= complete && op_load_q;
      if (issue) begin
        dmem_req_q   <= 1'b1;
        dmem_we_q    <= mem_write_MEMPREP;
        dmem_addr_q  <= addr_word[ADDR_W-1:0];
        dmem_wdata_q <= mem_write_MEMPREP ? lane_wdata : 32'd0;
        dmem_wstrb_q <= mem_write_MEMPREP ? lane_wstrb : 4'd0;
        op_load_q    <= mem_read_MEMPREP;
        op_funct3_q  <= funct3_MEMPREP;
        op_off_q     <= off;
      end
      if (complete) begin
        dmem_req_q <= 1'b0;
        if (op_load_q) begin
          load_result_q <= extend_load(op_funct3_q, op_off_q, dmem_rdata);
        end
      end
    end
  end

  assign dmem_req         = dmem_req_q;
  assign dmem_we          = dmem_we_q;
  assign dmem_addr        = dmem_addr_q;
  assign dmem_wdata       = dmem_wdata_q;
  assign dmem_wstrb       = dmem_wstrb_q;
  assign load_result      = load_result_q;
  assign load_valid       = load_valid_q;
  assign misaligned_fault = fault_q;

endmodule

// File: tb/tb_memory_access_unit.sv
module tb_memory_access_unit;

  localparam int K_NONE  = 0;
  localparam int K_ACC   = 1;
  localparam int K_FAULT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        invalid_MEMPREP = 1'b1;
  logic        mem_read_MEMPREP = 1'b0;
  logic        mem_write_MEMPREP = 1'b0;
  logic [2:0]  funct3_MEMPREP = 3'd0;
  logic [31:0] alu_result_MEMPREP = 32'd0;
  logic [31:0] store_data_MEMPREP = 32'd0;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic [31:0] load_result;
  logic        load_valid;
  logic        misaligned_fault;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_result = 32'd0;

  always #5 clk = ~clk;

  memory_access_unit #(.ADDR_W(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .invalid_MEMPREP    (invalid_MEMPREP),
    .mem_read_MEMPREP   (mem_read_MEMPREP),
    .mem_write_MEMPREP  (mem_write_MEMPREP),
    .funct3_MEMPREP     (funct3_MEMPREP),
    .alu_result_MEMPREP (alu_result_MEMPREP),
    .store_data_MEMPREP (store_data_MEMPREP),
    .stall              (stall),
    .dmem_req           (dmem_req),
    .dmem_we            (dmem_we),
    .dmem_addr          (dmem_addr),
    .dmem_wdata         (dmem_wdata),
    .dmem_wstrb         (dmem_wstrb),
    .dmem_ready         (dmem_ready),
    .dmem_rdata         (dmem_rdata),
    .load_result        (load_result),
    .load_valid         (load_valid),
    .misaligned_fault   (misaligned_fault)
  );

  typedef struct {
    logic        inval;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          waits;
    int          kind;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_result;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic inval, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] sdata, input logic [31:0] rdata,
                              input int waits, input int kind,
                              input logic [31:0] exp_addr, input logic [3:0] exp_wstrb,
                              input logic [31:0] exp_wdata, input logic [31:0] exp_result);
    vec_t v;
    v.inval = inval; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr;
    v.sdata = sdata; v.rdata = rdata; v.waits = waits; v.kind = kind;
    v.exp_addr = exp_addr; v.exp_wstrb = exp_wstrb;
    v.exp_wdata = exp_wdata; v.exp_result = exp_result;
    return v;
  endfunction

  // Reference model: derives expectations from the access rules with plain
  // arithmetic (sizes in bytes, shifts and masks).
  function automatic vec_t model(input logic inval, input logic rd, input logic wr,
                                 input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] sdata, input logic [31:0] rdata,
                                 input int waits);
    vec_t v;
    int size_b;
    int offs;
    logic legal;
    logic [31:0] mask;
    logic [31:0] tmp;
    logic [1:0] szc;
    v = mk(inval, rd, wr, f3, addr, sdata, rdata, waits, K_NONE, 0, 0, 0, 0);
    szc = f3[1:0];
    size_b = 1 << szc;
    offs = int'(addr % 4);
    if (inval || (!rd && !wr)) begin
      v.kind = K_NONE;
    end else if (rd && wr) begin
      v.kind = K_FAULT;
    end else begin
      legal = rd ? (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7) : (f3 <= 3'd2);
      if (!legal || (offs % size_b) != 0) begin
        v.kind = K_FAULT;
      end else begin
        v.kind = K_ACC;
        v.exp_addr = addr - 32'(offs);
        if (wr) begin
          v.exp_wstrb = 4'(((1 << size_b) - 1) << offs);
          if (size_b == 1)      v.exp_wdata = {24'd0, sdata[7:0]} * 32'h0101_0101;
          else if (size_b == 2) v.exp_wdata = {16'd0, sdata[15:0]} * 32'h0001_0001;
          else                  v.exp_wdata = sdata;
        end else begin
          mask = (size_b == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size_b)) - 32'd1);
          tmp  = (rdata >> (8 * offs)) & mask;
          if (!f3[2] && size_b < 4 && tmp[8 * size_b - 1]) tmp = tmp | ~mask;
          v.exp_result = tmp;
        end
      end
    end
    return v;
  endfunction

  task automatic set_bubble();
    invalid_MEMPREP = 1'b1;
    mem_read_MEMPREP = 1'b0;
    mem_write_MEMPREP = 1'b0;
  endtask

  task automatic run_op(input vec_t v, input string tag);
    @(negedge clk);
    invalid_MEMPREP = v.inval;
    mem_read_MEMPREP = v.rd;
    mem_write_MEMPREP = v.wr;
    funct3_MEMPREP = v.f3;
    alu_result_MEMPREP = v.addr;
    store_data_MEMPREP = v.sdata;
    dmem_ready = 1'b0;
    #1;
    chk({tag, " stall_detect"}, {31'd0, stall}, (v.kind == K_ACC) ? 32'd1 : 32'd0);
    chk({tag, " req_idle"}, {31'd0, dmem_req}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    if (v.kind == K_ACC) begin
      chk({tag, " we"}, {31'd0, dmem_we}, {31'd0, v.wr});
      chk({tag, " addr"}, dmem_addr, v.exp_addr);
      chk({tag, " wstrb"}, {28'd0, dmem_wstrb}, {28'd0, v.exp_wstrb});
      if (v.wr) chk({tag, " wdata"}, dmem_wdata, v.exp_wdata);
      for (int w = 0; w <= v.waits; w++) begin
        dmem_ready = (w == v.waits);
        dmem_rdata = (w == v.waits) ? v.rdata : $urandom;
        #1;
        chk({tag, " busy_req"}, {31'd0, dmem_req}, 32'd1);
        chk({tag, " busy_stall"}, {31'd0, stall}, 32'd1);
        chk({tag, " busy_addr_held"}, dmem_addr, v.exp_addr);
        @(posedge clk);
        @(negedge clk);
      end
      dmem_ready = 1'b0;
      dmem_rdata = $urandom;
      #1;
      chk({tag, " done_stall"}, {31'd0, stall}, 32'd0);
      chk({tag, " done_req"}, {31'd0, dmem_req}, 32'd0);
      chk({tag, " done_load_valid"}, {31'd0, load_valid}, {31'd0, v.rd});
      if (v.rd) last_result = v.exp_result;
      chk({tag, " load_result"}, load_result, last_result);
      chk({tag, " done_fault"}, {31'd0, misaligned_fault}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      set_bubble();
      #1;
      chk({tag, " after_req"}, {31'd0, dmem_req}, 32'd0);
      chk({tag, " after_valid"}, {31'd0, load_valid}, 32'd0);
      chk({tag, " after_stall"}, {31'd0, stall}, 32'd0);
    end else begin
      set_bubble();
      #1;
      chk({tag, " fault_pulse"}, {31'd0, misaligned_fault}, (v.kind == K_FAULT) ? 32'd1 : 32'd0);
      chk({tag, " no_req"}, {31'd0, dmem_req}, 32'd0);
      chk({tag, " no_stall"}, {31'd0, stall}, 32'd0);
      chk({tag, " no_valid"}, {31'd0, load_valid}, 32'd0);
      chk({tag, " load_result_held"}, load_result, last_result);
      @(posedge clk);
      @(negedge clk);
      chk({tag, " fault_one_cycle"}, {31'd0, misaligned_fault}, 32'd0);
      chk({tag, " still_no_req"}, {31'd0, dmem_req}, 32'd0);
    end
  endtask

  vec_t table_v[12];

  initial begin
    // Hand-derived vectors: inval rd wr f3 addr sdata rdata waits kind exp_addr wstrb wdata result
    table_v[0]  = mk(0,1,0,3'b010,32'h0000_0104,32'h0,        32'hDEAD_BEEF,1,K_ACC,  32'h104,4'b0000,32'h0,        32'hDEAD_BEEF);
    table_v[1]  = mk(0,0,1,3'b000,32'h0000_0103,32'h0000_00AB,32'h0,        0,K_ACC,  32'h100,4'b1000,32'hABAB_ABAB,32'h0);
    table_v[2]  = mk(0,1,0,3'b001,32'h0000_0102,32'h0,        32'h8000_1234,0,K_ACC,  32'h100,4'b0000,32'h0,        32'hFFFF_8000);
    table_v[3]  = mk(0,1,0,3'b101,32'h0000_0102,32'h0,        32'h8000_1234,2,K_ACC,  32'h100,4'b0000,32'h0,        32'h0000_8000);
    table_v[4]  = mk(0,1,0,3'b010,32'h0000_0101,32'h0,        32'h0,        0,K_FAULT,32'h0,  4'b0000,32'h0,        32'h0);
    table_v[5]  = mk(0,0,1,3'b001,32'h0000_0201,32'h1234,     32'h0,        0,K_FAULT,32'h0,  4'b0000,32'h0,        32'h0);
    table_v[6]  = mk(1,1,0,3'b010,32'h0000_0100,32'h0,        32'h0,        0,K_NONE, 32'h0,  4'b0000,32'h0,        32'h0);
    table_v[7]  = mk(0,1,1,3'b010,32'h0000_0100,32'h0,        32'h0,        0,K_FAULT,32'h0,  4'b0000,32'h0,        32'h0);
    table_v[8]  = mk(0,1,0,3'b000,32'h0000_0101,32'h0,        32'h1234_F678,0,K_ACC,  32'h100,4'b0000,32'h0,        32'hFFFF_FFF6);
    table_v[9]  = mk(0,0,1,3'b010,32'h0000_0208,32'h1122_3344,32'h0,        1,K_ACC,  32'h208,4'b1111,32'h1122_3344,32'h0);
    table_v[10] = mk(0,1,0,3'b011,32'h0000_0100,32'h0,        32'h0,        0,K_FAULT,32'h0,  4'b0000,32'h0,        32'h0);
    table_v[11] = mk(0,0,1,3'b001,32'h0000_0206,32'h0000_CAFE,32'h0,        0,K_ACC,  32'h204,4'b1100,32'hCAFE_CAFE,32'h0);

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset req", {31'd0, dmem_req}, 32'd0);
    chk("reset we", {31'd0, dmem_we}, 32'd0);
    chk("reset addr", dmem_addr, 32'd0);
    chk("reset wdata", dmem_wdata, 32'd0);
    chk("reset wstrb", {28'd0, dmem_wstrb}, 32'd0);
    chk("reset load_result", load_result, 32'd0);
    chk("reset load_valid", {31'd0, load_valid}, 32'd0);
    chk("reset fault", {31'd0, misaligned_fault}, 32'd0);

    // Ready asserted outside BUSY must be ignored.
    dmem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dmem_ready = 1'b0;
    #1;
    chk("idle_ready req", {31'd0, dmem_req}, 32'd0);
    chk("idle_ready valid", {31'd0, load_valid}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      $display("vec %0d: rd=%0d wr=%0d inval=%0d f3=%0d addr=0x%08h kind=%0d",
               i, table_v[i].rd, table_v[i].wr, table_v[i].inval, table_v[i].f3,
               table_v[i].addr, table_v[i].kind);
      run_op(table_v[i], $sformatf("vec%0d", i));
    end

    // Reset while an access is outstanding; a late ready must be ignored.
    @(negedge clk);
    invalid_MEMPREP = 1'b0;
    mem_read_MEMPREP = 1'b1;
    mem_write_MEMPREP = 1'b0;
    funct3_MEMPREP = 3'b010;
    alu_result_MEMPREP = 32'h0000_0300;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_mid busy_req", {31'd0, dmem_req}, 32'd1);
    set_bubble();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dmem_ready = 1'b1;
    dmem_rdata = 32'h5555_AAAA;
    #1;
    chk("rst_mid req", {31'd0, dmem_req}, 32'd0);
    chk("rst_mid stall", {31'd0, stall}, 32'd0);
    chk("rst_mid addr", dmem_addr, 32'd0);
    @(posedge clk);
    @(negedge clk);
    dmem_ready = 1'b0;
    #1;
    chk("rst_mid no_valid", {31'd0, load_valid}, 32'd0);
    chk("rst_mid load_result", load_result, 32'd0);
    chk("rst_mid req_after", {31'd0, dmem_req}, 32'd0);
    chk("rst_mid stall_after", {31'd0, stall}, 32'd0);
    last_result = 32'd0;
    $display("rst_mid: req=%0d stall=%0d load_valid=%0d", dmem_req, stall, load_valid);

    // Randomized ops against the reference model.
    for (int i = 0; i < 60; i++) begin
      int sel;
      logic inval, rd, wr;
      logic [2:0] f3;
      logic [31:0] addr;
      vec_t v;
      sel = int'($urandom_range(0, 9));
      inval = ($urandom_range(0, 9) == 0);
      rd = (sel <= 4) || (sel == 9);
      wr = (sel >= 5);
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                       : (rd ? 3'($urandom_range(0, 2)) | (($urandom_range(0, 1) == 1) ? 3'b100 : 3'b000)
                                             : 3'($urandom_range(0, 2)));
      if (rd && f3 == 3'b110) f3 = 3'b100;
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      v = model(inval, rd, wr, f3, addr, $urandom, $urandom, int'($urandom_range(0, 3)));
      $display("rnd %0d: rd=%0d wr=%0d inval=%0d f3=%0d addr=0x%08h kind=%0d",
               i, v.rd, v.wr, v.inval, v.f3, v.addr, v.kind);
      run_op(v, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
